// File: rtl/gpr_file_pkg.sv
// -----------------------------------------------------------------------------
// gpr_file_pkg
// Shared register-file definitions for the MIPS32 pipeline: bus widths,
// register count, canonical zero word / NOP register address, enable levels
// and the active-low reset-asserted level. Imported by every gpr_* file so
// none of these values is redefined locally.
// -----------------------------------------------------------------------------
package gpr_file_pkg;

    // Register data bus (RegBus) and register address bus (RegAddrBus)
    localparam int unsigned REG_BUS_W      = 32'd32;
    localparam int unsigned REG_ADDR_BUS_W = 32'd5;

    // Register count (RegNum) and its log2 (RegNumLog2)
    localparam int unsigned REG_NUM        = 32'd32;
    localparam int unsigned REG_NUM_LOG2   = 32'd5;

    // Canonical constants
    localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = 32'h0000_0000;
    localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = 5'd0;

    // Enable levels
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Reset-asserted level of the active-low reset (RstEnable_n)
    localparam logic RST_ENABLE_N  = 1'b0;

endpackage : gpr_file_pkg

// File: rtl/gpr_file_read_port.sv
// -----------------------------------------------------------------------------
// gpr_read_port
// Combinational read mux for one register-file read port. Applies, in order:
// reset forces zero, register 0 reads zero, same-cycle write bypass, array
// read, and finally zero when the port is not enabled.
//
// Ports:
//   rst      in  1       active-low reset (0 = asserted)
//   re       in  1       read enable
//   raddr    in  ADDR_W  read address
//   we       in  1       write enable of the write port (for bypass)
//   waddr    in  ADDR_W  write address (for bypass)
//   wdata    in  DATA_W  write data (for bypass)
//   arr_data in  DATA_W  array contents at raddr
//   rdata    out DATA_W  read data
// -----------------------------------------------------------------------------
module gpr_read_port
    import gpr_file_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS_W,
    parameter int unsigned ADDR_W = REG_ADDR_BUS_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] arr_data,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_s;

    // Read priority mux; register 0 beats the bypass so a write to r0 never leaks
    always_comb begin
        rdata_s = '0;
        if (rst == RST_ENABLE_N) begin
            rdata_s = '0;
        end else if (raddr == '0) begin
            rdata_s = '0;
        end else if ((re == READ_ENABLE) && (we == WRITE_ENABLE) && (raddr == waddr)) begin
            rdata_s = wdata;
        end else if (re == READ_ENABLE) begin
            rdata_s = arr_data;
        end else begin
            rdata_s = '0;
        end
    end

    assign rdata = rdata_s;

endmodule : gpr_read_port

// File: rtl/gpr_file.sv
// -----------------------------------------------------------------------------
// gpr_file
// 32 x 32-bit general-purpose register file for the 5-stage MIPS32 pipeline.
// One write port fed by write-back, two combinational read ports serving
// decode, with same-cycle write-to-read bypass. Register 0 always reads 0.
// The array clears asynchronously while rst is low.
//
// Ports:
//   clk    in  1       pipeline clock, array updates on rising edge
//   rst    in  1       asynchronous active-low reset (0 = asserted)
//   we     in  1       write enable
//   waddr  in  ADDR_W  write destination register
//   wdata  in  DATA_W  write data
//   re1    in  1       read port 1 enable
//   raddr1 in  ADDR_W  read port 1 address
//   rdata1 out DATA_W  read port 1 data (combinational)
//   re2    in  1       read port 2 enable
//   raddr2 in  ADDR_W  read port 2 address
//   rdata2 out DATA_W  read port 2 data (combinational)
// -----------------------------------------------------------------------------
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int unsigned DATA_W  = REG_BUS_W,
    parameter int unsigned ADDR_W  = REG_ADDR_BUS_W,
    parameter int unsigned REG_NUM = gpr_file_pkg::REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // Register array; entry 0 is never written so it stays at its reset zero
    logic [REG_NUM-1:0][DATA_W-1:0] regs_q;
    logic [REG_NUM-1:0][DATA_W-1:0] regs_d;

    // Next-state of the array: single write port, writes to r0 dropped
    always_comb begin
        regs_d = regs_q;
        if ((we == WRITE_ENABLE) && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Array storage; reset clears every entry and discards a coincident write
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    gpr_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .rst      (rst),
        .re       (re1),
        .raddr    (raddr1),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .arr_data (regs_q[raddr1]),
        .rdata    (rdata1)
    );

    gpr_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .rst      (rst),
        .re       (re2),
        .raddr    (raddr2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .arr_data (regs_q[raddr2]),
        .rdata    (rdata2)
    );

endmodule : gpr_file

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- General-purpose register file for the 5-stage MIPS32 pipeline: 32 x 32-bit registers, two read ports and one write port.
- Responder to the decode stage's register-read requests. It serves read enable and address, and returns data in the same cycle.
- Fed on its write side by the write-back stage.
- Supplies same-cycle write-to-read bypass so that decode sees a value written this cycle. Older in-flight results are forwarded by decode itself, not by this block.

Parameters:
- DATA_W, 32, register and data width (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- REG_NUM, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  pipeline clock; array writes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- we  input  1  write enable from write-back stage.
- waddr  input  ADDR_W  destination register of write.
- wdata  input  DATA_W  data to write.
- re1  input  1  read port 1 enable (decode reg1_read).
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- re2  input  1  read port 2 enable (decode reg2_read).
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data, combinational.

Behaviour:
- Storage:
  - REG_NUM x DATA_W array.
  - Register 0 is hardwired to zero: never written, always reads 0.
- Reset:
  - rst low clears all array entries to 0 asynchronously, without waiting for clk.
  - rdata1 and rdata2 are forced to 0 while rst is low, regardless of re/raddr.
  - Writes are ignored while rst is low.
  - Reset asserted mid-operation discards any write pending at that edge; the array reads all-zero on the first cycle after release.
- Write:
  - On a rising clk with rst high, we=1 and waddr!=0: array[waddr] <= wdata.
  - we=1 with waddr=0 is a silent no-op.
  - we=0 leaves the array unchanged.
  - Write latency is 1 cycle: the array holds the new value from the next cycle.
- Read (per port, identical logic, evaluated in this priority order):
  1. rst low -> 0.
  2. raddr==0 -> 0, regardless of re and of any write to 0.
  3. re=1 and we=1 and raddr==waddr -> wdata (same-cycle bypass, 0-cycle latency).
  4. re=1 -> array[raddr].
  5. re=0 -> 0.
- Both ports may address the same register simultaneously; both receive identical data, including the bypass case.
- No read-modify-write hazards exist internally: one write port, no pending-write state beyond the array.
- Address width: with REG_NUM equal to 2**ADDR_W there are no out-of-range addresses and no wrap-around.
- Timing: the read paths are purely combinational from inputs to rdata. There are no registered outputs and no handshake beyond the enables.

Decomposition:
- Shared defines header, not redefined locally: RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, ReadEnable/ReadDisable.
- Add to the same header: RstEnable_n = 1'b0, the active-low reset-asserted level.
- One sub-module is natural: gpr_read_port. It is the combinational per-port mux implementing the read priority list, instantiated twice.
- The array and write logic stay in gpr_file.

Test Plan:
1. Reset clears the array.
   - Stimulus: write 0x12345678 to r5; drop rst to 0 asynchronously, mid-cycle; release; read r5 on port1 with re1=1.
   - Required: rdata1=0 while rst is low; rdata1=0x00000000 after release.
2. Basic write then read.
   - Stimulus: we=1, waddr=3, wdata=0xDEADBEEF for one edge; then we=0, re1=1, raddr1=3, re2=1, raddr2=3.
   - Required: rdata1=rdata2=0xDEADBEEF.
3. Same-cycle bypass.
   - Stimulus: r7 holds 0x11111111; in one cycle we=1, waddr=7, wdata=0x22222222, re1=1, raddr1=7.
   - Required: rdata1=0x22222222 in that same cycle, before the edge; array[7]=0x22222222 after the edge.
4. Register 0 immutability.
   - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF; re1=1, raddr1=0 in the same cycle and in the next cycle.
   - Required: rdata1=0 in both cycles.
5. Read enable gating.
   - Stimulus: r9=0xA5A5A5A5; re2=0, raddr2=9; then also we=1, waddr=9, wdata=0x5A5A5A5A with re2=0.
   - Required: rdata2=0 in both cases; with re2=1 on the following cycle, rdata2=0x5A5A5A5A.
6. Independent ports.
   - Stimulus: r1=0x00000001, r31=0x80000000; re1=1, raddr1=31, re2=1, raddr2=1, with a concurrent write of 0xCAFEF00D to r31.
   - Required: rdata1=0xCAFEF00D (bypass) and rdata2=0x00000001.
